// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-entry skid buffer for responses
// that arrive while decode is stalled, redirect handling, and the IF/ID
// pipeline register set (InstrD, PCD, PCPlus4D, ValidD).
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        Stall,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemRdy,
    input  logic [31:0] IMemData,
    output logic [31:0] InstrD,
    output logic [6:0]  OpD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_BUF   = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] skid_buf;
    logic [31:0] redirect_pc;

    // Word-aligned successor address; wraps naturally at 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] a);
        return a + 32'd4;
    endfunction

    // Word-aligned predecessor address, used to recover the buffered word's PC.
    function automatic logic [31:0] pc_dec(input logic [31:0] a);
        return a - 32'd4;
    endfunction

    // Low two bits of the redirect target are dropped to keep the PC word aligned.
    assign redirect_pc = PCTarget & ~32'h3;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect overrides everything else.
    always_comb begin
        state_next = state;
        if (PCSrc) begin
            state_next = S_REDIR;
        end else begin
            case (state)
                S_FETCH, S_REDIR: begin
                    if (IMemRdy && Stall) begin
                        state_next = S_BUF;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
                S_BUF: begin
                    if (!Stall) begin
                        state_next = S_FETCH;
                    end
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

    // Outputs: request is outstanding unless a word is parked in the skid buffer.
    always_comb begin
        IMemReq  = (state != S_BUF);
        IMemAddr = pc;
        OpD      = InstrD[6:0];
    end

    // PC, skid buffer and IF/ID registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC & ~32'h3;
            skid_buf <= 32'h0;
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (PCSrc) begin
            // Flush: any word returned this cycle and any buffered word are dropped.
            pc       <= redirect_pc;
            skid_buf <= 32'h0;
            InstrD   <= NOP_INSTR;
            ValidD   <= 1'b0;
        end else begin
            case (state)
                S_FETCH, S_REDIR: begin
                    if (!Stall) begin
                        if (IMemRdy) begin
                            InstrD   <= IMemData;
                            PCD      <= pc;
                            PCPlus4D <= pc_inc(pc);
                            ValidD   <= 1'b1;
                            pc       <= pc_inc(pc);
                        end else begin
                            InstrD <= NOP_INSTR;
                            ValidD <= 1'b0;
                        end
                    end else if (IMemRdy) begin
                        // Decode is busy: park the response, keep IF/ID as is.
                        skid_buf <= IMemData;
                        pc       <= pc_inc(pc);
                    end
                end
                S_BUF: begin
                    if (!Stall) begin
                        InstrD   <= skid_buf;
                        PCD      <= pc_dec(pc);
                        PCPlus4D <= pc;
                        ValidD   <= 1'b1;
                    end
                end
                default: begin
                    InstrD <= NOP_INSTR;
                    ValidD <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a driver issues directed then random
// stimulus and pushes every accepted fetch into an in-order queue; a monitor
// pops and compares whenever the IF/ID register is expected to update.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = 32'h0;
    logic        Stall = 1'b0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemRdy = 1'b0;
    logic [31:0] IMemData;
    logic [31:0] InstrD;
    logic [6:0]  OpD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .Stall(Stall), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemRdy(IMemRdy), .IMemData(IMemData), .InstrD(InstrD), .OpD(OpD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A0F0F;
    endfunction

    assign IMemData = mem_word(IMemAddr);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc = 32'h0;
    logic        m_held = 1'b0;
    bit          m_init = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          deliveries = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: check fetch-side outputs against the model,
    // apply inputs, and record what the coming edge should accept.
    task automatic drive(input logic r, input logic rdy, input logic st,
                         input logic src, input logic [31:0] tgt);
        @(negedge clk);
        if (m_init) begin
            chk("imem_req", {31'b0, IMemReq}, {31'b0, !m_held});
            chk("imem_addr", IMemAddr, m_pc);
        end
        reset = r; IMemRdy = rdy; Stall = st; PCSrc = src; PCTarget = tgt;
        if (r) begin
            q.delete(); m_pc = RESET_PC; m_held = 1'b0; m_init = 1'b1;
        end else if (m_init) begin
            if (src) begin
                q.delete(); m_pc = {tgt[31:2], 2'b00}; m_held = 1'b0;
            end else if (!m_held) begin
                if (rdy) begin
                    q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                    if (st) m_held = 1'b1;
                end
            end else if (!st) begin
                m_held = 1'b0;
            end
        end
    endtask

    // Monitor: expected IF/ID contents evolve by the delivery rules.
    logic [31:0] e_instr = NOP;
    logic [31:0] e_pc = 32'h0;
    logic        e_valid = 1'b0;
    bit          mon_init = 1'b0;

    initial begin
        ent_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mon_init = 1'b1;
                e_instr = NOP; e_valid = 1'b0; e_pc = 32'h0;
                chk("reset_pcd", PCD, 32'h0);
                chk("reset_pcplus4d", PCPlus4D, 32'h0);
            end else if (mon_init) begin
                if (PCSrc) begin
                    e_instr = NOP; e_valid = 1'b0;
                end else if (!Stall) begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        e_instr = e.instr; e_pc = e.pc; e_valid = 1'b1;
                        deliveries++;
                    end else begin
                        e_instr = NOP; e_valid = 1'b0;
                    end
                end
            end
            if (mon_init) begin
                chk("validd", {31'b0, ValidD}, {31'b0, e_valid});
                chk("instrd", InstrD, e_instr);
                chk("opd", {25'b0, OpD}, {25'b0, e_instr[6:0]});
                if (e_valid) begin
                    chk("pcd", PCD, e_pc);
                    chk("pcplus4d", PCPlus4D, e_pc + 32'd4);
                end
            end
        end
    end

    initial begin
        logic r, rdy, st, src;
        logic [31:0] tgt;
        // Reset, then a stream with memory always ready.
        drive(1, 0, 0, 0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        repeat (6) drive(0, 1, 0, 0, 32'h0);
        // Memory wait states.
        drive(0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        drive(0, 1, 0, 0, 32'h0);
        // Stall with a response captured into the skid buffer.
        repeat (3) drive(0, 1, 1, 0, 32'h0);
        repeat (3) drive(0, 1, 0, 0, 32'h0);
        // Redirect while buffered and stalled; buffered word must be lost.
        drive(0, 1, 1, 0, 32'h0);
        drive(0, 1, 1, 1, 32'h00000103);
        repeat (3) drive(0, 1, 0, 0, 32'h0);
        // Address wrap at the top of memory.
        drive(0, 1, 0, 1, 32'hFFFFFFF8);
        repeat (4) drive(0, 1, 0, 0, 32'h0);
        // Reset mid-stall with buffer full, redirect asserted alongside.
        drive(0, 1, 1, 0, 32'h0);
        drive(0, 1, 1, 0, 32'h0);
        drive(1, 1, 1, 1, 32'h00000040);
        repeat (3) drive(0, 1, 0, 0, 32'h0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom % 100) < 1;
            rdy = ($urandom % 100) < 70;
            st  = ($urandom % 100) < 30;
            src = ($urandom % 100) < 5;
            tgt = ($urandom % 2) ? $urandom : (32'hFFFFFFF0 | ($urandom % 16));
            drive(r, rdy, st, src, tgt);
        end
        repeat (3) drive(0, 1, 0, 0, 32'h0);
        checks++;
        if (deliveries < 200) begin
            failures++;
            $display("FAIL delivery_count actual=%0d required>=200", deliveries);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, first fetch address after reset.
REQ-002 Parameter: NOP_INSTR, 32'h00000013, instruction word presented on InstrD when no valid instruction is held.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: PCSrc  input  1  redirect request from execute (branch taken).
REQ-006 Port: PCTarget  input  32  redirect address; bits [1:0] ignored.
REQ-007 Port: Stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-008 Port: IMemReq  output  1  instruction memory request valid.
REQ-009 Port: IMemAddr  output  32  instruction memory word address, bits [1:0] always 00.
REQ-010 Port: IMemRdy  input  1  memory returns IMemData for the current request this cycle.
REQ-011 Port: IMemData  input  32  instruction word from memory.
REQ-012 Port: InstrD  output  32  IF/ID instruction register.
REQ-013 Port: OpD  output  7  InstrD[6:0], the opcode field driven to the main decoder.
REQ-014 Port: PCD  output  32  address of InstrD.
REQ-015 Port: PCPlus4D  output  32  PCD + 4, modulo 2^32.
REQ-016 Port: ValidD  output  1  InstrD holds a real fetched instruction.

Function
REQ-017 The block SHALL implement three states: FETCH (request outstanding), BUF (response captured while stalled), REDIR (one-cycle bubble after redirect).
REQ-018 The block SHALL hold a 32-bit PC register, a 32-bit skid buffer, and the IF/ID registers InstrD, PCD, PCPlus4D and ValidD.
REQ-019 IMemReq SHALL be 1 in FETCH and REDIR and 0 in BUF; IMemAddr SHALL equal PC at all times.
REQ-020 In FETCH with IMemRdy=1 and Stall=0, the block SHALL, on the next edge, load InstrD=IMemData, PCD=PC, PCPlus4D=PC+4 and ValidD=1, set PC to PC+4, and remain in FETCH; fetch-to-decode latency is one cycle after IMemRdy.
REQ-021 In FETCH with IMemRdy=0 and Stall=0, the block SHALL load InstrD=NOP_INSTR and ValidD=0 (bubble), and leave PC unchanged.
REQ-022 With Stall=1, InstrD, PCD, PCPlus4D and ValidD SHALL hold their values.
REQ-023 In FETCH with IMemRdy=1 and Stall=1, the block SHALL store IMemData in the skid buffer, advance PC by 4, and enter BUF.
REQ-024 In BUF with Stall=0, the block SHALL move the buffer into InstrD (PCD=PC-4, PCPlus4D=PC, ValidD=1) and return to FETCH; with Stall=1 it SHALL remain in BUF.
REQ-025 PCSrc=1 SHALL take priority over Stall, IMemRdy and the current state: on the next edge PC={PCTarget[31:2],2'b00}, the skid buffer is discarded, InstrD=NOP_INSTR, ValidD=0, and the state becomes REDIR.
REQ-026 Any IMemData returned in the same cycle as PCSrc=1 SHALL be discarded.
REQ-027 REDIR SHALL behave as FETCH for the new PC in the cycle that follows; the flush bubble is therefore exactly one cycle when memory is ready.
REQ-028 While IMemReq=1 and IMemRdy=0, IMemAddr SHALL remain stable unless PCSrc=1 occurs.
REQ-029 PC arithmetic SHALL wrap: PC=32'hFFFFFFFC advances to 32'h00000000.
REQ-030 OpD SHALL be combinationally equal to InstrD[6:0].

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL set PC=RESET_PC, state=FETCH, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0 and ValidD=0, and SHALL clear the skid buffer.
REQ-032 reset SHALL override PCSrc and Stall, and SHALL abandon any outstanding request mid-operation; the first request after reset SHALL be to RESET_PC.

Verification
REQ-033 Memory always ready, no stall, 4 cycles after reset: InstrD/PCD sequence at addresses 0x0, 0x4, 0x8, 0xC with ValidD=1 each cycle; OpD tracks InstrD[6:0].
REQ-034 Memory ready with 2-cycle wait (IMemRdy=0,0,1): IMemAddr stays at 0x4 for 3 cycles; ValidD=0 for 2 cycles, then InstrD=word@0x4.
REQ-035 Stall=1 for 3 cycles while IMemRdy=1 at PC=0x8: InstrD holds word@0x4, IMemReq drops after 1 cycle; on release, InstrD=word@0x8, then fetch resumes at 0xC with no instruction lost or duplicated.
REQ-036 PCSrc=1 with PCTarget=0x103 while Stall=1 and state BUF: next cycle ValidD=0, InstrD=0x00000013, IMemAddr=0x100; buffered word is never delivered.
REQ-037 PC=0xFFFFFFFC fetched: PCPlus4D=0x00000000 and next IMemAddr=0x00000000.
REQ-038 Assert reset for one cycle mid-stall with the buffer full: ValidD=0, IMemAddr=RESET_PC the next cycle; PCSrc asserted with reset is ignored.
